// File: rtl/seg7_scan_driver.sv
// Time-multiplexed scan driver for two 4-digit seven-segment banks with per-frame shadowing.
// Optional feature: define SEG7_SCAN_DIM_EN to add the 2-bit `dim` brightness port.
module seg7_scan_driver #(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic        clk_pin,
  input  logic        rst_n,
  input  logic [31:0] data,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  blank,
`ifdef SEG7_SCAN_DIM_EN
  input  logic [1:0]  dim,
`endif
  output logic [6:0]  seg7_0_7bit,
  output logic [6:0]  seg7_1_7bit,
  output logic [3:0]  seg7_0_an,
  output logic [3:0]  seg7_1_an,
  output logic        seg7_0_dp,
  output logic        seg7_1_dp,
  output logic        frame_tick
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  if (SCAN_DIV < 4 || CLK_HZ == 0) begin : g_bad_cfg
    $error("seg7_scan_driver: SCAN_DIV must be >= 4 and CLK_HZ non-zero");
  end

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       pos_q, pos_d;
  logic [31:0]      data_sh_q, data_sh_d;
  logic [7:0]       dp_sh_q, dp_sh_d;
  logic [7:0]       blank_sh_q, blank_sh_d;
  logic [6:0]       seg0_q, seg0_d, seg1_q, seg1_d;
  logic [3:0]       an0_q, an0_d, an1_q, an1_d;
  logic             dp0_q, dp0_d, dp1_q, dp1_d;
  logic             frame_tick_q, frame_tick_d;

  logic             tick;
  logic             load;
  logic             win_on;
  logic [3:0]       pos_onehot;
  logic [3:0]       blank0, blank1, dpv0, dpv1;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    return 7'h3F;
      4'h1:    return 7'h06;
      4'h2:    return 7'h5B;
      4'h3:    return 7'h4F;
      4'h4:    return 7'h66;
      4'h5:    return 7'h6D;
      4'h6:    return 7'h7D;
      4'h7:    return 7'h07;
      4'h8:    return 7'h7F;
      4'h9:    return 7'h6F;
      4'hA:    return 7'h77;
      4'hB:    return 7'h7C;
      4'hC:    return 7'h39;
      4'hD:    return 7'h5E;
      4'hE:    return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  function automatic logic [3:0] nib_at(input logic [15:0] half, input logic [1:0] p);
    case (p)
      2'd0:    return half[3:0];
      2'd1:    return half[7:4];
      2'd2:    return half[11:8];
      default: return half[15:12];
    endcase
  endfunction

`ifdef SEG7_SCAN_DIM_EN
  localparam int unsigned QUARTER = SCAN_DIV / 4;

  if (SCAN_DIV % 4 != 0) begin : g_bad_dim_cfg
    $error("seg7_scan_driver: SCAN_DIV must be a multiple of 4 when dimming is enabled");
  end

  // Anodes lit only in the leading (dim+1) quarters of each slot; dim is not shadowed.
  assign win_on = (32'(div_cnt_q) < (QUARTER * (32'(dim) + 32'd1)));
`else
  assign win_on = 1'b1;
`endif

  assign blank0 = blank_sh_q[7:4];
  assign blank1 = blank_sh_q[3:0];
  assign dpv0   = dp_sh_q[7:4];
  assign dpv1   = dp_sh_q[3:0];

  always_comb begin
    tick         = (div_cnt_q == DIV_LAST);
    load         = tick && (pos_q == 2'd3);
    div_cnt_d    = tick ? '0 : div_cnt_q + DIV_W'(1);
    pos_d        = tick ? pos_q + 2'd1 : pos_q;
    frame_tick_d = load;
    data_sh_d    = data_sh_q;
    dp_sh_d      = dp_sh_q;
    blank_sh_d   = blank_sh_q;
    if (load) begin
      data_sh_d  = data;
      dp_sh_d    = dp_in;
      blank_sh_d = blank;
    end
  end

  // Outside the dim window seg/dp keep their last value; only the anodes drop.
  always_comb begin
    pos_onehot = 4'b0001 << pos_q;
    seg0_d     = seg0_q;
    dp0_d      = dp0_q;
    an0_d      = '0;
    seg1_d     = seg1_q;
    dp1_d      = dp1_q;
    an1_d      = '0;

    if (blank0[pos_q]) begin
      seg0_d = '0;
      dp0_d  = 1'b0;
    end else if (win_on) begin
      seg0_d = hex_to_seg(nib_at(data_sh_q[31:16], pos_q));
      dp0_d  = dpv0[pos_q];
      an0_d  = pos_onehot;
    end

    if (blank1[pos_q]) begin
      seg1_d = '0;
      dp1_d  = 1'b0;
    end else if (win_on) begin
      seg1_d = hex_to_seg(nib_at(data_sh_q[15:0], pos_q));
      dp1_d  = dpv1[pos_q];
      an1_d  = pos_onehot;
    end
  end

  always_ff @(posedge clk_pin or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      pos_q        <= '0;
      data_sh_q    <= '0;
      dp_sh_q      <= '0;
      blank_sh_q   <= '1;
      seg0_q       <= '0;
      seg1_q       <= '0;
      an0_q        <= '0;
      an1_q        <= '0;
      dp0_q        <= 1'b0;
      dp1_q        <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      pos_q        <= pos_d;
      data_sh_q    <= data_sh_d;
      dp_sh_q      <= dp_sh_d;
      blank_sh_q   <= blank_sh_d;
      seg0_q       <= seg0_d;
      seg1_q       <= seg1_d;
      an0_q        <= an0_d;
      an1_q        <= an1_d;
      dp0_q        <= dp0_d;
      dp1_q        <= dp1_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg7_0_7bit = seg0_q;
  assign seg7_1_7bit = seg1_q;
  assign seg7_0_an   = an0_q;
  assign seg7_1_an   = an1_q;
  assign seg7_0_dp   = dp0_q;
  assign seg7_1_dp   = dp1_q;
  assign frame_tick  = frame_tick_q;

endmodule
